// File: rtl/comb2_pkg.sv
// comb2_pkg: shared constants and result payload type for the comb2 block.
//   OPW             operand / result width
//   *_POS constants bit positions of the individual flags inside the
//                   Relational, Equality, Reduction and Logical results
//   results_t       packed bundle of the nine 4-bit results
package comb2_pkg;

    localparam int unsigned OPW = 4;

    // Relational = {A>B, A<B, A>=D, B<=C}
    localparam int unsigned REL_A_GT_B_POS = 3;
    localparam int unsigned REL_A_LT_B_POS = 2;
    localparam int unsigned REL_A_GE_D_POS = 1;
    localparam int unsigned REL_B_LE_C_POS = 0;

    // Equality = {A==D, A==B, A!=C, B!=D}
    localparam int unsigned EQ_A_EQ_D_POS = 3;
    localparam int unsigned EQ_A_EQ_B_POS = 2;
    localparam int unsigned EQ_A_NE_C_POS = 1;
    localparam int unsigned EQ_B_NE_D_POS = 0;

    // Reduction = {&A, |B, ^C, ~^D}
    localparam int unsigned RED_AND_A_POS  = 3;
    localparam int unsigned RED_OR_B_POS   = 2;
    localparam int unsigned RED_XOR_C_POS  = 1;
    localparam int unsigned RED_XNOR_D_POS = 0;

    // Logical = {A&&B, C||D, !A, !(C&&D)}
    localparam int unsigned LOG_A_AND_B_POS  = 3;
    localparam int unsigned LOG_C_OR_D_POS   = 2;
    localparam int unsigned LOG_NOT_A_POS    = 1;
    localparam int unsigned LOG_NAND_C_D_POS = 0;

    typedef struct packed {
        logic [OPW-1:0] arith;
        logic [OPW-1:0] shift;
        logic [OPW-1:0] rel;
        logic [OPW-1:0] eq;
        logic [OPW-1:0] bitw;
        logic [OPW-1:0] red;
        logic [OPW-1:0] lgc;
        logic [OPW-1:0] concat;
        logic [OPW-1:0] cond;
    } results_t;

endpackage

// File: rtl/comb2_if.sv
// comb2_if: operand/result bus of the comb2 block.
//   in_valid, A, B, C, D     operand capture strobe and operands (master drives)
//   out_valid + nine results registered results (slave drives)
//   modport master: operand source / result sink
//   modport slave : the comb2 block
interface comb2_if;
    import comb2_pkg::*;

    logic           in_valid;
    logic [OPW-1:0] A;
    logic [OPW-1:0] B;
    logic [OPW-1:0] C;
    logic [OPW-1:0] D;

    logic           out_valid;
    logic [OPW-1:0] Arithmetic;
    logic [OPW-1:0] Shift;
    logic [OPW-1:0] Relational;
    logic [OPW-1:0] Equality;
    logic [OPW-1:0] Bitwise;
    logic [OPW-1:0] Reduction;
    logic [OPW-1:0] Logical;
    logic [OPW-1:0] Concatenation;
    logic [OPW-1:0] Conditional;

    modport master (
        output in_valid, A, B, C, D,
        input  out_valid, Arithmetic, Shift, Relational, Equality,
               Bitwise, Reduction, Logical, Concatenation, Conditional
    );

    modport slave (
        input  in_valid, A, B, C, D,
        output out_valid, Arithmetic, Shift, Relational, Equality,
               Bitwise, Reduction, Logical, Concatenation, Conditional
    );

endinterface

// File: rtl/comb2_ops.sv
// comb2_ops: purely combinational operator bank for comb2.
//   a, b, c, d  unsigned operands
//   res_c       all nine results, computed every cycle
// Parameter SHIFT_AMT (0..3): right-shift distance applied to a.
// Macro COMB2_SAT_ARITH_EN: when defined the sum saturates to all-ones on
// carry-out; otherwise it wraps.
module comb2_ops
    import comb2_pkg::*;
#(
    parameter int unsigned SHIFT_AMT = 1
) (
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic [OPW-1:0] c,
    input  logic [OPW-1:0] d,
    output results_t       res_c
);

    localparam int unsigned SUMW = OPW + 1;

    logic [SUMW-1:0] sum_c;

    // Extended sum so the carry-out is visible.
    assign sum_c = SUMW'(a) + SUMW'(b);

    // Operator bank; flag fields are built bit by bit at their named positions.
    always_comb begin
        res_c = '0;

`ifdef COMB2_SAT_ARITH_EN
        res_c.arith = sum_c[OPW] ? {OPW{1'b1}} : sum_c[OPW-1:0];
`else
        res_c.arith = sum_c[OPW-1:0];
`endif

        res_c.shift = a >> SHIFT_AMT;

        res_c.rel[REL_A_GT_B_POS] = (a >  b);
        res_c.rel[REL_A_LT_B_POS] = (a <  b);
        res_c.rel[REL_A_GE_D_POS] = (a >= d);
        res_c.rel[REL_B_LE_C_POS] = (b <= c);

        res_c.eq[EQ_A_EQ_D_POS] = (a == d);
        res_c.eq[EQ_A_EQ_B_POS] = (a == b);
        res_c.eq[EQ_A_NE_C_POS] = (a != c);
        res_c.eq[EQ_B_NE_D_POS] = (b != d);

        res_c.bitw = (a & b) | (c ^ d);

        res_c.red[RED_AND_A_POS]  = &a;
        res_c.red[RED_OR_B_POS]   = |b;
        res_c.red[RED_XOR_C_POS]  = ^c;
        res_c.red[RED_XNOR_D_POS] = ~^d;

        res_c.lgc[LOG_A_AND_B_POS]  = (|a) && (|b);
        res_c.lgc[LOG_C_OR_D_POS]   = (|c) || (|d);
        res_c.lgc[LOG_NOT_A_POS]    = ~(|a);
        res_c.lgc[LOG_NAND_C_D_POS] = ~((|c) && (|d));

        res_c.concat = {a[1:0], b[1:0]};

        res_c.cond = (a > b) ? c : d;
    end

endmodule

// File: rtl/comb2.sv
// comb2: registers the comb2_ops results on an in_valid strobe.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears results and out_valid
//   bus    comb2_if.slave: in_valid/A..D in, out_valid + nine results out
// Parameter SHIFT_AMT (0..3), default 1.
// Macro COMB2_SAT_ARITH_EN selects the saturating Arithmetic result.
// Results update only on a captured in_valid and hold otherwise; out_valid
// is in_valid delayed by one cycle.
module comb2
    import comb2_pkg::*;
#(
    parameter int unsigned SHIFT_AMT = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    comb2_if.slave bus
);

    results_t res_c;
    results_t res_q;
    logic     valid_q;

    comb2_ops #(
        .SHIFT_AMT (SHIFT_AMT)
    ) u_ops (
        .a     (bus.A),
        .b     (bus.B),
        .c     (bus.C),
        .d     (bus.D),
        .res_c (res_c)
    );

    // Result capture and valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                res_q <= res_c;
            end
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.Arithmetic    = res_q.arith;
    assign bus.Shift         = res_q.shift;
    assign bus.Relational    = res_q.rel;
    assign bus.Equality      = res_q.eq;
    assign bus.Bitwise       = res_q.bitw;
    assign bus.Reduction     = res_q.red;
    assign bus.Logical       = res_q.lgc;
    assign bus.Concatenation = res_q.concat;
    assign bus.Conditional   = res_q.cond;

endmodule

// File: tb/tb_comb2.sv
// tb_comb2: directed-vector self-checking bench for comb2 (SHIFT_AMT = 1).
// Expected values are hand-computed; the Arithmetic expectations follow
// COMB2_SAT_ARITH_EN when the bench is built with that macro.
module tb_comb2;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

`ifdef COMB2_SAT_ARITH_EN
    localparam logic [3:0] ARITH_V1    = 4'b1111;
    localparam logic [3:0] ARITH_CARRY = 4'b1111;
`else
    localparam logic [3:0] ARITH_V1    = 4'b0010;
    localparam logic [3:0] ARITH_CARRY = 4'b0000;
`endif

    comb2_if bus ();

    comb2 #(
        .SHIFT_AMT (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag,
                             input logic [3:0] ar, input logic [3:0] sh,
                             input logic [3:0] re, input logic [3:0] eq,
                             input logic [3:0] bw, input logic [3:0] rd,
                             input logic [3:0] lg, input logic [3:0] cc,
                             input logic [3:0] cd, input logic ov);
        check({tag, ".arith"},  bus.Arithmetic,    ar);
        check({tag, ".shift"},  bus.Shift,         sh);
        check({tag, ".rel"},    bus.Relational,    re);
        check({tag, ".eq"},     bus.Equality,      eq);
        check({tag, ".bitw"},   bus.Bitwise,       bw);
        check({tag, ".red"},    bus.Reduction,     rd);
        check({tag, ".logic"},  bus.Logical,       lg);
        check({tag, ".concat"}, bus.Concatenation, cc);
        check({tag, ".cond"},   bus.Conditional,   cd);
        check({tag, ".valid"},  {3'b000, bus.out_valid}, {3'b000, ov});
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        bus.in_valid = v;
        bus.A = a;
        bus.B = b;
        bus.C = c;
        bus.D = d;
    endtask

    // Advance past the next rising edge and settle for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_all(tag, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic check_v1(input string tag, input logic ov);
        check_all(tag, ARITH_V1, 4'b0110, 4'b1010, 4'b1011, 4'b1110,
                  4'b0111, 4'b1100, 4'b0010, 4'b0010, ov);
    endtask

    task automatic check_v2(input string tag, input logic ov);
        check_all(tag, 4'b1000, 4'b0001, 4'b0111, 4'b0011, 4'b1111,
                  4'b0101, 4'b1101, 4'b1101, 4'b0000, ov);
    endtask

    task automatic check_carry(input string tag, input logic ov);
        check_all(tag, ARITH_CARRY, 4'b0111, 4'b1011, 4'b0011, 4'b1111,
                  4'b1101, 4'b1100, 4'b1101, 4'b0101, ov);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset state, and no capture while reset is held across edges.
        #2;
        check_zero("reset");
        drive(1'b1, 4'b1100, 4'b0110, 4'b0010, 4'b1100);
        step();
        check_zero("reset_held");

        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;

        // Vector 1 capture.
        @(negedge clk);
        drive(1'b1, 4'b1100, 4'b0110, 4'b0010, 4'b1100);
        step();
        check_v1("v1", 1'b1);

        // Hold for three cycles with changing operands.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 4'(i + 3), 4'b0101, 4'b1111, 4'(i));
            step();
            check_v1($sformatf("hold%0d", i), 1'b0);
        end

        // Vector 2 capture.
        @(negedge clk);
        drive(1'b1, 4'b0011, 4'b0101, 4'b1111, 4'b0000);
        step();
        check_v2("v2", 1'b1);

        // Back-to-back: all-zero operands then a carry-out vector.
        @(negedge clk);
        drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step();
        check_all("zeros", 4'b0000, 4'b0000, 4'b0011, 4'b1100, 4'b0000,
                  4'b0001, 4'b0011, 4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        drive(1'b1, 4'b1111, 4'b0001, 4'b0101, 4'b1010);
        step();
        check_carry("carry", 1'b1);

        // Idle cycle: results hold, valid drops.
        @(negedge clk);
        drive(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        step();
        check_carry("idle", 1'b0);

        // Asynchronous reset between edges with a capture pending.
        @(negedge clk);
        drive(1'b1, 4'b0011, 4'b0101, 4'b1111, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        step();
        check_zero("async_rst_edge");

        // First capture after release comes from the operands present then.
        @(negedge clk);
        drive(1'b1, 4'b1100, 4'b0110, 4'b0010, 4'b1100);
        rst_n = 1'b1;
        step();
        check_v1("post_rst", 1'b1);

        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        step();
        check_v1("post_rst_hold", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comb2.md
COMB2 -- requirements
Module: comb2

Interface
REQ-001 Parameter SHIFT_AMT, default 1: right-shift distance applied to A for the Shift output; legal range 0..3.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 in_valid  input  1  operand-capture strobe.
REQ-005 A, B, C, D  input  4 each  unsigned operands.
REQ-006 out_valid  output  1  high the cycle after a captured in_valid.
REQ-007 Arithmetic  output  4  registered sum result.
REQ-008 Shift  output  4  registered shift result.
REQ-009 Relational  output  4  registered magnitude-compare flags.
REQ-010 Equality  output  4  registered equality flags.
REQ-011 Bitwise  output  4  registered bitwise result.
REQ-012 Reduction  output  4  registered reduction flags.
REQ-013 Logical  output  4  registered logical flags.
REQ-014 Concatenation  output  4  registered concatenation.
REQ-015 Conditional  output  4  registered select result.

Function
REQ-016 All operands are unsigned; all results are exactly 4 bits, MSB first as listed below.
REQ-017 Arithmetic SHALL be (A + B) mod 16, carry discarded (see REQ-031 for the saturating variant).
REQ-018 Shift SHALL be A logically shifted right by SHIFT_AMT, zero-filled.
REQ-019 Relational SHALL be {A>B, A<B, A>=D, B<=C}.
REQ-020 Equality SHALL be {A==D, A==B, A!=C, B!=D}.
REQ-021 Bitwise SHALL be (A & B) | (C ^ D).
REQ-022 Reduction SHALL be {&A, |B, ^C, ~^D}.
REQ-023 Logical SHALL be {A&&B, C||D, !A, !(C&&D)}; an operand is true when nonzero.
REQ-024 Concatenation SHALL be {A[1:0], B[1:0]}.
REQ-025 Conditional SHALL be C when A>B, otherwise D.
REQ-026 On a rising clk with in_valid=1, all nine results SHALL be computed from the current A..D and registered; latency is exactly one cycle.
REQ-027 With in_valid=0, all result outputs SHALL hold their previous values.
REQ-028 out_valid SHALL be the registered in_valid; back-to-back in_valid produces back-to-back results, one per cycle.

Reset
REQ-029 While rst_n=0, all nine result outputs and out_valid SHALL be 0, asynchronously, regardless of clk.
REQ-030 Reset asserted mid-stream SHALL discard any pending capture; the first capture after release occurs on the first rising clk edge with rst_n=1 and in_valid=1.

Configuration
REQ-031 When macro COMB2_SAT_ARITH_EN is defined, Arithmetic SHALL saturate to 4'b1111 on carry-out; when undefined, it SHALL wrap mod 16; no other output is affected.

Structure
REQ-032 Package comb2_pkg SHALL hold the operand width constant (4) and the result bit-position constants for the flag outputs.
REQ-033 The combinational operator logic SHALL live in a sub-module comb2_ops, with comb2 adding only the registers and valid pipeline.

Verification
REQ-034 A=1100 B=0110 C=0010 D=1100, in_valid pulse -> next cycle: Arithmetic=0010 (1111 with COMB2_SAT_ARITH_EN), Shift=0110, Relational=1010, Equality=1011, Bitwise=1110, Reduction=0111, Logical=1100, Concatenation=0010, Conditional=0010, out_valid=1.
REQ-035 A=0011 B=0101 C=1111 D=0000, in_valid pulse -> Arithmetic=1000, Shift=0001, Relational=0111, Equality=0011, Bitwise=1111, Reduction=0101, Logical=1101, Concatenation=1101, Conditional=0000.
REQ-036 After REQ-034 capture, change operands with in_valid=0 for 3 cycles -> outputs unchanged, out_valid=0.
REQ-037 Assert rst_n=0 between clock edges after a capture -> all outputs become 0 immediately, before the next edge.
REQ-038 A=0000 B=0000 C=0000 D=0000 -> Arithmetic=0000, Relational=0011, Equality=1100, Reduction=0001, Logical=0011, Conditional=0000.
